// File: rtl/irq_defs.sv
// Shared constants for the interrupt arbiter: state encoding and default sizing.
package irq_defs;

  localparam int NLINES_DEF = 8;
  localparam int VW_DEF     = 3;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_ACK     = 2'd2;
  localparam logic [1:0] ST_RECOVER = 2'd3;

endpackage

// File: rtl/irq_arbiter_prio_enc.sv
// Combinational priority encoder: the lowest set index wins; any flags a non-empty input.
module irq_prio_enc
  import irq_defs::*;
#(
  parameter int NLINES = NLINES_DEF,
  parameter int VW     = VW_DEF
) (
  input  logic [NLINES-1:0] req,
  output logic [VW-1:0]     idx,
  output logic              any
);

  always_comb begin
    idx = '0;
    any = |req;
    // Scan downwards so the lowest set bit is the final assignment.
    for (int i = NLINES - 1; i >= 0; i--) begin
      if (req[i]) idx = VW'(i);
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt arbiter: synchronises active-low edge requests into pending bits, masks them,
// and runs the nirq / acknowledge handshake with the interrupt FSM.
//
//  state      | meaning
//  -----------+------------------------------------------------------------
//  ST_IDLE    | no request outstanding, nirq high, waiting for an enabled pending line
//  ST_REQ     | nirq low for the frozen winner, waiting for nack
//  ST_ACK     | vector presented with vecvalid high until nack releases
//  ST_RECOVER | one cycle with nirq high so the FSM sees a gap between requests
module irq_arbiter
  import irq_defs::*;
#(
  parameter int NLINES = NLINES_DEF,
  parameter int VW     = VW_DEF
) (
  input  logic              clk4,
  input  logic              reset,
  input  logic [NLINES-1:0] nirqin,
  input  logic [NLINES-1:0] ibus,
  input  logic              nmaskwe,
  input  logic              nack,
  output logic              nirq,
  output logic [VW-1:0]     vector,
  output logic              vecvalid,
  output logic [NLINES-1:0] pending,
  output logic [NLINES-1:0] ien
);

  logic [NLINES-1:0] sync1_q, sync1_d;
  logic [NLINES-1:0] sync2_q, sync2_d;
  logic [NLINES-1:0] prev_q, prev_d;
  logic [NLINES-1:0] pending_q, pending_d;
  logic [NLINES-1:0] ien_q, ien_d;
  logic [1:0]        state_q, state_d;
  logic [VW-1:0]     win_q, win_d;
  logic [VW-1:0]     vector_q, vector_d;
  logic              vecvalid_q, vecvalid_d;
  logic              nirq_q, nirq_d;

  logic [NLINES-1:0] fall;
  logic [NLINES-1:0] clr;
  logic [NLINES-1:0] active;
  logic [VW-1:0]     sel_idx;
  logic              sel_any;

  assign active = pending_q & ien_q;

  irq_prio_enc #(
    .NLINES(NLINES),
    .VW    (VW)
  ) u_prio_enc (
    .req(active),
    .idx(sel_idx),
    .any(sel_any)
  );

  always_comb begin
    sync1_d    = nirqin;
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    fall       = ~sync2_q & prev_q;
    clr        = '0;
    ien_d      = nmaskwe ? ien_q : ibus;
    state_d    = state_q;
    win_d      = win_q;
    vector_d   = vector_q;
    vecvalid_d = vecvalid_q;
    nirq_d     = nirq_q;

    case (state_q)
      ST_IDLE: begin
        if (sel_any) begin
          win_d   = sel_idx;
          state_d = ST_REQ;
          nirq_d  = 1'b0;
        end
      end
      ST_REQ: begin
        if (!nack) begin
          state_d      = ST_ACK;
          vector_d     = win_q;
          vecvalid_d   = 1'b1;
          nirq_d       = 1'b1;
          clr[win_q]   = 1'b1;
        end else if (!ien_q[win_q]) begin
          state_d = ST_IDLE;
          nirq_d  = 1'b1;
        end
      end
      ST_ACK: begin
        if (nack) begin
          state_d    = ST_RECOVER;
          vecvalid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A fresh edge on the line being retired must survive the clear.
    pending_d = (pending_q & ~clr) | fall;
  end

  always_ff @(posedge clk4 or posedge reset) begin
    if (reset) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      prev_q     <= '1;
      pending_q  <= '0;
      ien_q      <= '0;
      state_q    <= ST_IDLE;
      win_q      <= '0;
      vector_q   <= '0;
      vecvalid_q <= 1'b0;
      nirq_q     <= 1'b1;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      pending_q  <= pending_d;
      ien_q      <= ien_d;
      state_q    <= state_d;
      win_q      <= win_d;
      vector_q   <= vector_d;
      vecvalid_q <= vecvalid_d;
      nirq_q     <= nirq_d;
    end
  end

  assign nirq     = nirq_q;
  assign vector   = vector_q;
  assign vecvalid = vecvalid_q;
  assign pending  = pending_q;
  assign ien      = ien_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench for irq_arbiter: directed scenarios plus a randomized run,
// all compared every cycle against a transaction-level reference model.
module tb_irq_arbiter;

  localparam int NL  = 8;
  localparam int VWL = 3;

  logic           clk4 = 1'b0;
  logic           reset;
  logic [NL-1:0]  nirqin;
  logic [NL-1:0]  ibus;
  logic           nmaskwe;
  logic           nack;
  logic           nirq;
  logic [VWL-1:0] vector;
  logic           vecvalid;
  logic [NL-1:0]  pending;
  logic [NL-1:0]  ien;

  irq_arbiter #(.NLINES(NL), .VW(VWL)) dut (
    .clk4    (clk4),
    .reset   (reset),
    .nirqin  (nirqin),
    .ibus    (ibus),
    .nmaskwe (nmaskwe),
    .nack    (nack),
    .nirq    (nirq),
    .vector  (vector),
    .vecvalid(vecvalid),
    .pending (pending),
    .ien     (ien)
  );

  always #5 clk4 = ~clk4;

  int checks = 0;
  int errors = 0;

  // Reference model: input history per edge, pending/mask sets and a handshake phase
  // (0 = nothing outstanding, 1 = requesting, 2 = vector presented, 3 = gap cycle).
  logic [NL-1:0]  h1, h2, h3;
  logic [NL-1:0]  m_pend, m_ien;
  int             m_phase;
  int             m_win;
  logic [VWL-1:0] m_vec;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int first_set(input logic [NL-1:0] a);
    for (int i = 0; i < NL; i++) if (a[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    h1 = '1; h2 = '1; h3 = '1;
    m_pend = '0; m_ien = '0;
    m_phase = 0; m_win = 0; m_vec = '0;
  endtask

  // An edge at clock k registers a request if the input was high at k-3 and low at k-2.
  task automatic model_step(input logic [NL-1:0] nin, input logic [NL-1:0] ib,
                            input logic nmwe, input logic nk);
    logic [NL-1:0] newly, retire;
    int w;
    newly  = h3 & ~h2;
    retire = '0;
    case (m_phase)
      0: begin
        w = first_set(m_pend & m_ien);
        if (w >= 0) begin m_win = w; m_phase = 1; end
      end
      1: begin
        if (!nk) begin
          m_vec = m_win[VWL-1:0];
          retire[m_win] = 1'b1;
          m_phase = 2;
        end else if (!m_ien[m_win]) begin
          m_phase = 0;
        end
      end
      2: if (nk) m_phase = 3;
      default: m_phase = 0;
    endcase
    m_pend = (m_pend & ~retire) | newly;
    if (!nmwe) m_ien = ib;
    h3 = h2; h2 = h1; h1 = nin;
  endtask

  task automatic cyc();
    logic [NL-1:0] nin, ib;
    logic nmwe, nk, rst;
    nin = nirqin; ib = ibus; nmwe = nmaskwe; nk = nack; rst = reset;
    @(posedge clk4);
    if (rst) model_reset();
    else model_step(nin, ib, nmwe, nk);
    #1;
    check("nirq", {31'd0, nirq}, {31'd0, (m_phase == 1) ? 1'b0 : 1'b1});
    check("vecvalid", {31'd0, vecvalid}, {31'd0, (m_phase == 2) ? 1'b1 : 1'b0});
    check("vector", {29'd0, vector}, {29'd0, m_vec});
    check("pending", {24'd0, pending}, {24'd0, m_pend});
    check("ien", {24'd0, ien}, {24'd0, m_ien});
  endtask

  task automatic write_mask(input logic [NL-1:0] m);
    ibus = m; nmaskwe = 1'b0;
    cyc();
    nmaskwe = 1'b1;
  endtask

  int hs;
  logic vv_prev;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; nirqin = '1; ibus = '0; nmaskwe = 1'b1; nack = 1'b1;
    model_reset();
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    check("rst_nirq", {31'd0, nirq}, 32'd1);
    check("rst_pending", {24'd0, pending}, 32'h00);
    check("rst_ien", {24'd0, ien}, 32'h00);

    // 1: single request on line 5
    write_mask(8'hFF);
    nirqin[5] = 1'b0;
    cyc(); cyc(); cyc();
    check("t1_pending_n2", {24'd0, pending}, 32'h20);
    check("t1_nirq_n2", {31'd0, nirq}, 32'd1);
    cyc();
    check("t1_nirq_n3", {31'd0, nirq}, 32'd0);
    nack = 1'b0; cyc();
    check("t1_vector", {29'd0, vector}, 32'd5);
    check("t1_vecvalid", {31'd0, vecvalid}, 32'd1);
    check("t1_pending_clr", {24'd0, pending}, 32'h00);
    nack = 1'b1; nirqin[5] = 1'b1; cyc(); cyc();
    check("t1_idle_nirq", {31'd0, nirq}, 32'd1);
    cyc(); cyc();

    // 2: simultaneous edges on lines 6 and 2
    nirqin[6] = 1'b0; nirqin[2] = 1'b0;
    cyc(); cyc(); cyc();
    check("t2_pending", {24'd0, pending}, 32'h44);
    cyc();
    nack = 1'b0; cyc();
    check("t2_vector_first", {29'd0, vector}, 32'd2);
    check("t2_pending_after1", {24'd0, pending}, 32'h40);
    nack = 1'b1; cyc(); cyc(); cyc();
    check("t2_nirq_reassert", {31'd0, nirq}, 32'd0);
    nack = 1'b0; cyc();
    check("t2_vector_second", {29'd0, vector}, 32'd6);
    nack = 1'b1; nirqin = '1; cyc(); cyc(); cyc();

    // 3: masked request, then unmask
    write_mask(8'h00);
    nirqin[3] = 1'b0; cyc();
    nirqin[3] = 1'b1; cyc(); cyc(); cyc(); cyc();
    check("t3_pending", {24'd0, pending}, 32'h08);
    check("t3_nirq_masked", {31'd0, nirq}, 32'd1);
    write_mask(8'h08);
    cyc();
    check("t3_nirq_unmasked", {31'd0, nirq}, 32'd0);
    nack = 1'b0; cyc();
    check("t3_vector", {29'd0, vector}, 32'd3);
    nack = 1'b1; cyc(); cyc();

    // 4: mask removed while requesting cancels without a vector
    write_mask(8'hFF);
    nirqin[4] = 1'b0; cyc(); cyc(); cyc(); cyc();
    check("t4_nirq_req", {31'd0, nirq}, 32'd0);
    write_mask(8'h00);
    cyc();
    check("t4_nirq_cancel", {31'd0, nirq}, 32'd1);
    check("t4_vecvalid", {31'd0, vecvalid}, 32'd0);
    check("t4_pending", {24'd0, pending}, 32'h10);
    cyc(); cyc();
    check("t4_vecvalid_later", {31'd0, vecvalid}, 32'd0);
    nirqin[4] = 1'b1;
    write_mask(8'hFF);
    cyc();
    nack = 1'b0; cyc();
    check("t4_served_later", {29'd0, vector}, 32'd4);
    nack = 1'b1; cyc(); cyc(); cyc();

    // 5: held low line gives one handshake; re-edge in the retire cycle survives
    hs = 0; vv_prev = 1'b0;
    nirqin[1] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (vecvalid && !vv_prev) hs++;
      vv_prev = vecvalid;
      nack = nirq;
    end
    check("t5_handshakes", hs, 32'd1);
    nack = 1'b1; nirqin[1] = 1'b1; cyc(); cyc();
    nirqin[1] = 1'b0; cyc();
    nirqin[1] = 1'b1; cyc();
    nirqin[1] = 1'b0; cyc(); cyc();
    nack = 1'b0; cyc();
    check("t5_set_wins", {24'd0, pending}, 32'h02);
    check("t5_vector", {29'd0, vector}, 32'd1);
    nack = 1'b1; cyc(); cyc(); cyc();
    check("t5_second_req", {31'd0, nirq}, 32'd0);
    nack = 1'b0; cyc();
    check("t5_second_vv", {31'd0, vecvalid}, 32'd1);
    nack = 1'b1; nirqin[1] = 1'b1; cyc(); cyc(); cyc();

    // 6: asynchronous reset during the acknowledge phase
    nirqin[7] = 1'b0; cyc(); cyc(); cyc(); cyc();
    nack = 1'b0; cyc();
    check("t6_in_ack", {31'd0, vecvalid}, 32'd1);
    check("t6_vector", {29'd0, vector}, 32'd7);
    #1 reset = 1'b1;
    #1;
    check("t6_nirq", {31'd0, nirq}, 32'd1);
    check("t6_vector_rst", {29'd0, vector}, 32'd0);
    check("t6_vecvalid_rst", {31'd0, vecvalid}, 32'd0);
    check("t6_pending_rst", {24'd0, pending}, 32'h00);
    check("t6_ien_rst", {24'd0, ien}, 32'h00);
    nirqin = '1; nack = 1'b1;
    cyc();
    reset = 1'b0;
    cyc(); cyc(); cyc();

    // Randomized traffic against the model
    write_mask(8'hFF);
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < NL; b++) begin
        if (nirqin[b]) begin
          if ($urandom_range(15) == 0) nirqin[b] = 1'b0;
        end else if ($urandom_range(3) == 0) begin
          nirqin[b] = 1'b1;
        end
      end
      nack = ($urandom_range(1) == 0);
      if ($urandom_range(19) == 0) begin
        nmaskwe = 1'b0;
        ibus = NL'($urandom);
      end else begin
        nmaskwe = 1'b1;
      end
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
